// File: rtl/cpu_defs_pkg.sv
// Shared CPU datapath constants and encodings for the write-back / register-file slice.
package cpu_defs_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] REG_ZERO  = 5'd0;

  typedef enum logic {
    WE_DIS = 1'b0,
    WE_EN  = 1'b1
  } we_e;

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair: asynchronous clear, both halves loaded together when we is set.
module hilo_reg #(
  parameter int DATA_W = cpu_defs_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [DATA_W-1:0] hi_d,
  input  logic [DATA_W-1:0] lo_d,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (we) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB latch, 32-entry GPR file (r0 = 0), HI/LO pair and two read ports.
// Define REGFILE_BYPASS_EN to forward the pending MEM/WB write onto the read ports and HI/LO outputs.
module wb_regfile #(
  parameter int DATA_W = cpu_defs_pkg::DATA_W,
  parameter int ADDR_W = cpu_defs_pkg::ADDR_W,
  parameter int NREG   = cpu_defs_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              wb_stall,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  import cpu_defs_pkg::*;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;

  logic [DATA_W-1:0] gpr [NREG];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // A stall only kills the enables, so a stalled entry can never commit twice.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_we    <= WE_DIS;
      wb_waddr <= '0;
      wb_wdata <= '0;
      wb_whilo <= WE_DIS;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else if (wb_stall) begin
      wb_we    <= WE_DIS;
      wb_whilo <= WE_DIS;
    end else begin
      wb_we    <= mem_we;
      wb_waddr <= mem_waddr;
      wb_wdata <= mem_wdata;
      wb_whilo <= mem_whilo;
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
    end
  end

  // NOTE: the GPR array is deliberately reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (wb_we == WE_EN && wb_waddr != REG_ZERO) begin
      gpr[wb_waddr] <= wb_wdata;
    end
  end

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wb_whilo),
    .hi_d    (wb_hi),
    .lo_d    (wb_lo),
    .hi_q    (hi_q),
    .lo_q    (lo_q)
  );

  logic              re_v    [2];
  logic [ADDR_W-1:0] raddr_v [2];
  logic [DATA_W-1:0] rdata_v [2];

  assign re_v[0]    = re1;
  assign re_v[1]    = re2;
  assign raddr_v[0] = raddr1;
  assign raddr_v[1] = raddr2;
  assign rdata1     = rdata_v[0];
  assign rdata2     = rdata_v[1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rdata_v[k] = ZERO_WORD;
      if (re_v[k] && raddr_v[k] != REG_ZERO) begin
        rdata_v[k] = gpr[raddr_v[k]];
`ifdef REGFILE_BYPASS_EN
        if (wb_we == WE_EN && wb_waddr == raddr_v[k]) rdata_v[k] = wb_wdata;
`endif
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hi_o = wb_whilo ? wb_hi : hi_q;
  assign lo_o = wb_whilo ? wb_lo : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table plus bypass, HI/LO-stall and reset sequences.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        wb_stall;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .wb_stall  (wb_stall),
    .re1       (re1),
    .raddr1    (raddr1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        chk_hilo;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs [11];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_whilo = 1'b0;
    mem_hi    = '0;
    mem_lo    = '0;
    wb_stall  = 1'b0;
    re1       = 1'b0;
    raddr1    = '0;
    re2       = 1'b0;
    raddr2    = '0;
  endtask

  initial begin
    // Reads only look at registers committed at least two edges earlier, so both builds agree.
    vecs[0]  = '{1, 5'd5,  32'hDEADBEEF, 0, 32'h0, 32'h0, 0, 1, 5'd1,  1, 5'd2,  32'h0,        32'h0,        1, 32'h0,        32'h0};
    vecs[1]  = '{1, 5'd0,  32'hFFFFFFFF, 0, 32'h0, 32'h0, 0, 1, 5'd3,  1, 5'd4,  32'h0,        32'h0,        1, 32'h0,        32'h0};
    vecs[2]  = '{1, 5'd10, 32'h000000AA, 1, 32'h11111111, 32'h22222222, 0, 1, 5'd5, 1, 5'd0, 32'hDEADBEEF, 32'h0, 1, 32'h0, 32'h0};
    vecs[3]  = '{0, 5'd0,  32'h0,        0, 32'h0, 32'h0, 0, 0, 5'd5,  1, 5'd5,  32'h0,        32'hDEADBEEF, 0, 32'h0,        32'h0};
    vecs[4]  = '{0, 5'd0,  32'h0,        0, 32'h0, 32'h0, 0, 1, 5'd10, 1, 5'd5,  32'h000000AA, 32'hDEADBEEF, 1, 32'h11111111, 32'h22222222};
    vecs[5]  = '{1, 5'd5,  32'hCAFEF00D, 0, 32'h0, 32'h0, 1, 1, 5'd5,  1, 5'd10, 32'hDEADBEEF, 32'h000000AA, 1, 32'h11111111, 32'h22222222};
    vecs[6]  = '{0, 5'd0,  32'h0,        0, 32'h0, 32'h0, 0, 1, 5'd5,  1, 5'd10, 32'hDEADBEEF, 32'h000000AA, 1, 32'h11111111, 32'h22222222};
    vecs[7]  = '{0, 5'd0,  32'h0,        0, 32'h0, 32'h0, 0, 1, 5'd5,  1, 5'd31, 32'hDEADBEEF, 32'h0,        1, 32'h11111111, 32'h22222222};
    vecs[8]  = '{1, 5'd31, 32'hFFFFFFFF, 1, 32'h3, 32'h4, 0, 1, 5'd5,  1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1, 32'h11111111, 32'h22222222};
    vecs[9]  = '{0, 5'd0,  32'h0,        0, 32'h0, 32'h0, 0, 1, 5'd1,  1, 5'd0,  32'h0,        32'h0,        0, 32'h0,        32'h0};
    vecs[10] = '{0, 5'd0,  32'h0,        0, 32'h0, 32'h0, 0, 1, 5'd31, 1, 5'd10, 32'hFFFFFFFF, 32'h000000AA, 1, 32'h3,        32'h4};

    idle_inputs();
    reset_n = 1'b0;

    // Reset state: every register and HI/LO read 0 while reset is held.
    #2;
    re1 = 1'b1;
    re2 = 1'b1;
    for (int r = 1; r < 32; r++) begin
      raddr1 = 5'(r);
      raddr2 = 5'(32 - r);
      #1;
      check($sformatf("reset r%0d p1", r), rdata1, 32'h0);
      check($sformatf("reset r%0d p2", 32 - r), rdata2, 32'h0);
    end
    check("reset hi", hi_o, 32'h0);
    check("reset lo", lo_o, 32'h0);

    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      mem_we    = vecs[i].we;
      mem_waddr = vecs[i].waddr;
      mem_wdata = vecs[i].wdata;
      mem_whilo = vecs[i].whilo;
      mem_hi    = vecs[i].hi;
      mem_lo    = vecs[i].lo;
      wb_stall  = vecs[i].stall;
      re1       = vecs[i].re1;
      raddr1    = vecs[i].ra1;
      re2       = vecs[i].re2;
      raddr2    = vecs[i].ra2;
      #1;
      check($sformatf("v%0d rdata1", i), rdata1, vecs[i].e1);
      check($sformatf("v%0d rdata2", i), rdata2, vecs[i].e2);
      if (vecs[i].chk_hilo) begin
        check($sformatf("v%0d hi", i), hi_o, vecs[i].ehi);
        check($sformatf("v%0d lo", i), lo_o, vecs[i].elo);
      end
    end

    // Bypass: r7 written, read on both ports during latch, commit and after-commit cycles.
    @(negedge clk);
    idle_inputs();
    mem_we = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h12345678;
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    check("byp pre p1", rdata1, 32'h0);
    @(negedge clk);
    mem_we = 1'b0;
    #1;
    check("byp edge1 p1", rdata1, BYP ? 32'h12345678 : 32'h0);
    check("byp edge1 p2", rdata2, BYP ? 32'h12345678 : 32'h0);
    @(negedge clk);
    #1;
    check("byp edge2 p1", rdata1, 32'h12345678);
    check("byp edge2 p2", rdata2, 32'h12345678);
    re2 = 1'b0;
    #1;
    check("byp re2 off", rdata2, 32'h0);

    // HI/LO write under stall is dropped; without stall it lands.
    @(negedge clk);
    idle_inputs();
    mem_whilo = 1'b1; mem_hi = 32'hA5A5A5A5; mem_lo = 32'h5A5A5A5A; wb_stall = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    check("stall hi e1", hi_o, 32'h3);
    check("stall lo e1", lo_o, 32'h4);
    @(negedge clk);
    #1;
    check("stall hi e2", hi_o, 32'h3);
    check("stall lo e2", lo_o, 32'h4);
    mem_whilo = 1'b1; mem_hi = 32'hA5A5A5A5; mem_lo = 32'h5A5A5A5A;
    @(negedge clk);
    idle_inputs();
    #1;
    check("hilo hi e1", hi_o, BYP ? 32'hA5A5A5A5 : 32'h3);
    check("hilo lo e1", lo_o, BYP ? 32'h5A5A5A5A : 32'h4);
    @(negedge clk);
    #1;
    check("hilo hi e2", hi_o, 32'hA5A5A5A5);
    check("hilo lo e2", lo_o, 32'h5A5A5A5A);

    // Reset between latch edge and commit edge drops the r9 write.
    @(negedge clk);
    mem_we = 1'b1; mem_waddr = 5'd9; mem_wdata = 32'h1;
    @(posedge clk);
    #2;
    idle_inputs();
    reset_n = 1'b0;
    re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd5;
    #1;
    check("rst mid r9", rdata1, 32'h0);
    check("rst mid r5", rdata2, 32'h0);
    check("rst mid hi", hi_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("post rst r9", rdata1, 32'h0);
    check("post rst r5", rdata2, 32'h0);
    check("post rst lo", lo_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
